// File: rtl/coms_pkg.sv
// Shared constants and types for the motor-board RS485 framing layer.
// Used by the frame receiver and the byte-wise CRC16 helper.
package coms_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;  // x^16 + x^15 + x^2 + 1
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;

    localparam logic [31:0] STATUS         = 32'h1CEB00DA;
    localparam logic [31:0] SETPOINT       = 32'hD0D0D0D0;
    localparam logic [31:0] CONTROL_MODE   = 32'hBAADA555;
    localparam logic [31:0] STATUS_REQUEST = 32'h1CE1CEBB;

    localparam int CRC_BYTES     = 2;
    localparam int MIN_FRAME_LEN = CRC_BYTES + 1;
    localparam logic [7:0] STATUS_FRAME_LEN = 8'd21;

    typedef enum logic [1:0] {
        HUNT,
        RECEIVE,
        CHECK
    } rx_state_e;

endpackage

// File: rtl/coms_crc16_d8.sv
// Combinational CRC16 update for one byte, MSB of the byte shifted in first.
// Shared between the frame receiver and the transmitter.
module coms_crc16_d8
    import coms_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    always_comb begin
        // NOTE: blocking '=' is intentional here; each loop pass must see the previous pass's result.
        crc_out = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (crc_out[15] ^ data[i]) begin
                crc_out = {crc_out[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                crc_out = {crc_out[14:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/coms_frame_rx.sv
// RS485 frame receiver: hunts for programmable magic numbers, collects the payload,
// verifies CRC16, enforces an inter-byte timeout and keeps link-quality counters.
module coms_frame_rx
    import coms_pkg::*;
#(
    parameter int NUM_FRAME_TYPES   = 4,
    parameter int MAX_PAYLOAD_BYTES = 24,
    parameter int CLK_FREQ_HZ       = 50_000_000,
    parameter int BAUDRATE          = 2_000_000,
    parameter int TIMEOUT_BYTES     = 4,
    localparam int TYPE_W = (NUM_FRAME_TYPES > 1) ? $clog2(NUM_FRAME_TYPES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rx_valid,
    input  logic [7:0]                     rx_data,
    input  logic [NUM_FRAME_TYPES*32-1:0]  magic,
    input  logic [NUM_FRAME_TYPES*8-1:0]   frame_len,
    output logic                           frame_valid,
    output logic [TYPE_W-1:0]              frame_type,
    output logic [MAX_PAYLOAD_BYTES*8-1:0] payload,
    output logic [7:0]                     payload_len,
    output logic                           crc_error,
    output logic                           timeout_error,
    output logic                           busy,
    output logic [31:0]                    frames_ok,
    output logic [15:0]                    crc_err_count,
    output logic [15:0]                    timeout_count
);

    localparam int TIMEOUT_CYCLES = (CLK_FREQ_HZ / BAUDRATE) * 10 * TIMEOUT_BYTES;
    localparam int TMR_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BUF_W          = MAX_PAYLOAD_BYTES * 8;

    rx_state_e              state_q, state_d;
    // Only the last three bytes are stored; the fourth comes straight from rx_data.
    logic [23:0]            sr_q, sr_d;
    logic [TYPE_W-1:0]      slot_q, slot_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [15:0]            crc_q, crc_d;
    logic [7:0]             crc_hi_q, crc_hi_d;
    logic [7:0]             crc_lo_q, crc_lo_d;
    logic [BUF_W-1:0]       rx_buf_q, rx_buf_d;
    logic [BUF_W-1:0]       payload_q, payload_d;
    logic [7:0]             payload_len_q, payload_len_d;
    logic [TYPE_W-1:0]      frame_type_q, frame_type_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   crc_error_q, crc_error_d;
    logic                   timeout_error_q, timeout_error_d;
    logic [31:0]            frames_ok_q, frames_ok_d;
    logic [15:0]            crc_err_count_q, crc_err_count_d;
    logic [15:0]            timeout_count_q, timeout_count_d;

    logic [31:0]            sr_next;
    logic                   hit;
    logic [TYPE_W-1:0]      hit_idx;
    logic [7:0]             hit_len;
    logic [15:0]            crc_next;

    coms_crc16_d8 u_crc (
        .crc_in  (crc_q),
        .data    (rx_data),
        .crc_out (crc_next)
    );

    // Descending scan so the lowest matching slot index is the one kept.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sr_next = {sr_q, rx_data};
        hit     = 1'b0;
        hit_idx = '0;
        hit_len = '0;
        for (int i = NUM_FRAME_TYPES - 1; i >= 0; i--) begin
            if (magic[i*32 +: 32] != 32'h0 &&
                frame_len[i*8 +: 8] >= 8'(MIN_FRAME_LEN) &&
                frame_len[i*8 +: 8] <= 8'(MAX_PAYLOAD_BYTES + CRC_BYTES) &&
                sr_next == magic[i*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = TYPE_W'(i);
                hit_len = frame_len[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        sr_d            = sr_q;
        slot_d          = slot_q;
        len_d           = len_q;
        cnt_d           = cnt_q;
        timer_d         = timer_q;
        crc_d           = crc_q;
        crc_hi_d        = crc_hi_q;
        crc_lo_d        = crc_lo_q;
        rx_buf_d        = rx_buf_q;
        payload_d       = payload_q;
        payload_len_d   = payload_len_q;
        frame_type_d    = frame_type_q;
        frame_valid_d   = 1'b0;
        crc_error_d     = 1'b0;
        timeout_error_d = 1'b0;
        frames_ok_d     = frames_ok_q;
        crc_err_count_d = crc_err_count_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            HUNT: begin
                if (rx_valid) begin
                    sr_d = sr_next[23:0];
                    if (hit) begin
                        state_d = RECEIVE;
                        slot_d  = hit_idx;
                        len_d   = hit_len;
                        cnt_d   = '0;
                        timer_d = '0;
                        sr_d    = '0;
                        crc_d   = CRC_INIT;
                    end
                end
            end
            RECEIVE: begin
                if (rx_valid) begin
                    timer_d = '0;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q < 8'(MAX_PAYLOAD_BYTES)) begin
                        rx_buf_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    end
                    if (cnt_q < len_q - 8'd2) begin
                        crc_d = crc_next;
                    end else if (cnt_q == len_q - 8'd2) begin
                        crc_hi_d = rx_data;
                    end else begin
                        crc_lo_d = rx_data;
                        state_d  = CHECK;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_error_d = 1'b1;
                    if (timeout_count_q != '1) timeout_count_d = timeout_count_q + 16'd1;
                    state_d = HUNT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = HUNT;
                if (rx_valid) sr_d = sr_next[23:0];
                if (crc_q == {crc_hi_q, crc_lo_q}) begin
                    for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
                        payload_d[i*8 +: 8] = (i < int'(len_q) - CRC_BYTES) ? rx_buf_q[i*8 +: 8] : 8'h00;
                    end
                    payload_len_d = len_q - 8'd2;
                    frame_type_d  = slot_q;
                    frame_valid_d = 1'b1;
                    if (frames_ok_q != '1) frames_ok_d = frames_ok_q + 32'd1;
                end else begin
                    crc_error_d = 1'b1;
                    if (crc_err_count_q != '1) crc_err_count_d = crc_err_count_q + 16'd1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // NOTE: rx_buf is flops, not RAM, so it is cleared on reset like every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= HUNT;
            sr_q            <= '0;
            slot_q          <= '0;
            len_q           <= '0;
            cnt_q           <= '0;
            timer_q         <= '0;
            crc_q           <= '0;
            crc_hi_q        <= '0;
            crc_lo_q        <= '0;
            rx_buf_q        <= '0;
            payload_q       <= '0;
            payload_len_q   <= '0;
            frame_type_q    <= '0;
            frame_valid_q   <= 1'b0;
            crc_error_q     <= 1'b0;
            timeout_error_q <= 1'b0;
            frames_ok_q     <= '0;
            crc_err_count_q <= '0;
            timeout_count_q <= '0;
        end else begin
            // NOTE: non-blocking '<=' so every register samples pre-edge values.
            state_q         <= state_d;
            sr_q            <= sr_d;
            slot_q          <= slot_d;
            len_q           <= len_d;
            cnt_q           <= cnt_d;
            timer_q         <= timer_d;
            crc_q           <= crc_d;
            crc_hi_q        <= crc_hi_d;
            crc_lo_q        <= crc_lo_d;
            rx_buf_q        <= rx_buf_d;
            payload_q       <= payload_d;
            payload_len_q   <= payload_len_d;
            frame_type_q    <= frame_type_d;
            frame_valid_q   <= frame_valid_d;
            crc_error_q     <= crc_error_d;
            timeout_error_q <= timeout_error_d;
            frames_ok_q     <= frames_ok_d;
            crc_err_count_q <= crc_err_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign frame_valid   = frame_valid_q;
    assign frame_type    = frame_type_q;
    assign payload       = payload_q;
    assign payload_len   = payload_len_q;
    assign crc_error     = crc_error_q;
    assign timeout_error = timeout_error_q;
    assign busy          = (state_q != HUNT);
    assign frames_ok     = frames_ok_q;
    assign crc_err_count = crc_err_count_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_coms_frame_rx.sv
// Directed bench for coms_frame_rx: good/bad CRC, timeout, noise before magic,
// back-to-back frames, disabled slots and reset mid-frame.
module tb_coms_frame_rx;
    import coms_pkg::*;

    localparam int NT   = 4;
    localparam int MAXP = 24;

    typedef logic [7:0] bytes_t [0:MAXP-1];

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [NT*32-1:0]  magic;
    logic [NT*8-1:0]   frame_len;
    logic              frame_valid;
    logic [1:0]        frame_type;
    logic [MAXP*8-1:0] payload;
    logic [7:0]        payload_len;
    logic              crc_error;
    logic              timeout_error;
    logic              busy;
    logic [31:0]       frames_ok;
    logic [15:0]       crc_err_count;
    logic [15:0]       timeout_count;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    logic [1:0] fv_types [$];

    coms_frame_rx dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .magic         (magic),
        .frame_len     (frame_len),
        .frame_valid   (frame_valid),
        .frame_type    (frame_type),
        .payload       (payload),
        .payload_len   (payload_len),
        .crc_error     (crc_error),
        .timeout_error (timeout_error),
        .busy          (busy),
        .frames_ok     (frames_ok),
        .crc_err_count (crc_err_count),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the falling edge, well away from the main thread's sampling point.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            fv_types.push_back(frame_type);
        end
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input bytes_t pl, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {pl[i], 8'h00};
            for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [191:0] exp_payload(input bytes_t pl, input int n);
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = pl[i];
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Sends [magic] + payload + CRC; returns #1 after the edge sampling the last byte.
    task automatic send_frame(input logic [31:0] m, input bit with_magic, input int len,
                              input bytes_t pl, input logic [7:0] crc_xor, input int gap);
        logic [7:0]  seq [$];
        logic [15:0] c;
        c = crc_model(pl, len - 2);
        if (with_magic) begin
            seq.push_back(m[31:24]); seq.push_back(m[23:16]);
            seq.push_back(m[15:8]);  seq.push_back(m[7:0]);
        end
        for (int i = 0; i < len - 2; i++) seq.push_back(pl[i]);
        seq.push_back(c[15:8]);
        seq.push_back(c[7:0] ^ crc_xor);
        for (int i = 0; i < seq.size(); i++) begin
            send_byte(seq[i]);
            if (i != seq.size() - 1 && gap > 0) idle(gap);
        end
    endtask

    bytes_t pl0, pl1, pl2;
    logic [191:0] exp0, exp1, exp2;
    int base;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MAXP; i++) begin
            pl0[i] = (i < 19) ? 8'(i) : 8'h00;
            pl1[i] = 8'h00;
            pl2[i] = (i < 19) ? 8'(8'hA0 + i) : 8'h00;
        end
        pl1[0] = 8'h11; pl1[1] = 8'h22; pl1[2] = 8'h33;
        exp0 = exp_payload(pl0, 19);
        exp1 = exp_payload(pl1, 3);
        exp2 = exp_payload(pl2, 19);

        magic     = {32'h0, CONTROL_MODE, SETPOINT, STATUS};
        frame_len = {8'd5, 8'd2, 8'd5, STATUS_FRAME_LEN};
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        reset     = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);

        check("rst_busy", 192'(busy), 192'(0));
        check("rst_frames_ok", 192'(frames_ok), 192'(0));
        check("rst_crc_cnt", 192'(crc_err_count), 192'(0));
        check("rst_to_cnt", 192'(timeout_count), 192'(0));
        check("rst_payload", 192'(payload), 192'(0));
        check("rst_payload_len", 192'(payload_len), 192'(0));
        check("rst_fv", 192'(frame_valid), 192'(0));

        // Good slot-0 frame with 1-clk gaps
        send_frame(STATUS, 1'b1, 21, pl0, 8'h00, 1);
        check("t1_fv_early", 192'(frame_valid), 192'(0));
        check("t1_busy_check", 192'(busy), 192'(1));
        idle(1);
        check("t1_fv", 192'(frame_valid), 192'(1));
        check("t1_type", 192'(frame_type), 192'(0));
        check("t1_len", 192'(payload_len), 192'(19));
        check("t1_byte18", 192'(payload[18*8 +: 8]), 192'(8'h12));
        check("t1_payload", 192'(payload), exp0);
        check("t1_frames_ok", 192'(frames_ok), 192'(1));
        check("t1_busy_done", 192'(busy), 192'(0));
        idle(1);
        check("t1_fv_pulse", 192'(frame_valid), 192'(0));

        // Same frame, corrupted CRC low byte
        send_frame(STATUS, 1'b1, 21, pl0, 8'h01, 1);
        idle(1);
        check("t2_crc_err", 192'(crc_error), 192'(1));
        check("t2_fv", 192'(frame_valid), 192'(0));
        check("t2_crc_cnt", 192'(crc_err_count), 192'(1));
        check("t2_payload_kept", 192'(payload), exp0);
        idle(1);
        check("t2_crc_pulse", 192'(crc_error), 192'(0));
        check("t2_fv_total", 192'(fv_cnt), 192'(1));

        // Slot-1 partial frame then a stall
        send_byte(8'hD0); send_byte(8'hD0); send_byte(8'hD0); send_byte(8'hD0);
        send_byte(8'hA1); send_byte(8'hA2);
        idle(999);
        check("t3_to_early", 192'(timeout_error), 192'(0));
        check("t3_busy_wait", 192'(busy), 192'(1));
        idle(1);
        check("t3_to", 192'(timeout_error), 192'(1));
        check("t3_busy_hunt", 192'(busy), 192'(0));
        check("t3_to_cnt", 192'(timeout_count), 192'(1));
        idle(1);
        check("t3_to_pulse", 192'(timeout_error), 192'(0));
        send_frame(SETPOINT, 1'b1, 5, pl1, 8'h00, 1);
        idle(1);
        check("t3_fv", 192'(frame_valid), 192'(1));
        check("t3_type", 192'(frame_type), 192'(1));
        check("t3_len", 192'(payload_len), 192'(3));
        check("t3_payload", 192'(payload), exp1);
        check("t3_frames_ok", 192'(frames_ok), 192'(2));

        // Noise whose tail forms the real magic
        idle(2);
        send_byte(8'h1C); check("t4_noise0", 192'(busy), 192'(0));
        send_byte(8'hEB); check("t4_noise1", 192'(busy), 192'(0));
        send_byte(8'h1C); check("t4_noise2", 192'(busy), 192'(0));
        send_byte(8'hEB); check("t4_noise3", 192'(busy), 192'(0));
        send_byte(8'h00); check("t4_noise4", 192'(busy), 192'(0));
        send_byte(8'hDA); check("t4_match", 192'(busy), 192'(1));
        send_frame(STATUS, 1'b0, 21, pl2, 8'h00, 1);
        idle(1);
        check("t4_fv", 192'(frame_valid), 192'(1));
        check("t4_payload", 192'(payload), exp2);
        check("t4_frames_ok", 192'(frames_ok), 192'(3));

        // Back-to-back frames, zero gap
        idle(2);
        base = fv_cnt;
        send_frame(STATUS, 1'b1, 21, pl0, 8'h00, 0);
        send_frame(SETPOINT, 1'b1, 5, pl1, 8'h00, 0);
        idle(2);
        check("t5_fv_count", 192'(fv_cnt - base), 192'(2));
        if (fv_cnt - base == 2) begin
            check("t5_type_first", 192'(fv_types[base]), 192'(0));
            check("t5_type_second", 192'(fv_types[base + 1]), 192'(1));
        end
        check("t5_payload", 192'(payload), exp1);
        check("t5_frames_ok", 192'(frames_ok), 192'(5));

        // Disabled slots: magic=0 and frame_len=2
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("t6_magic0", 192'(busy), 192'(0));
        send_byte(8'hBA); send_byte(8'hAD); send_byte(8'hA5); send_byte(8'h55);
        check("t6_len2", 192'(busy), 192'(0));
        idle(2);
        check("t6_no_fv", 192'(fv_cnt), 192'(base + 2));

        // Reset in the middle of a frame
        send_byte(8'h1C); send_byte(8'hEB); send_byte(8'h00); send_byte(8'hDA);
        for (int i = 0; i < 7; i++) send_byte(pl0[i]);
        check("t7_busy_pre", 192'(busy), 192'(1));
        reset = 1'b1;
        idle(1);
        check("t7_busy", 192'(busy), 192'(0));
        check("t7_frames_ok", 192'(frames_ok), 192'(0));
        check("t7_crc_cnt", 192'(crc_err_count), 192'(0));
        check("t7_to_cnt", 192'(timeout_count), 192'(0));
        check("t7_payload", 192'(payload), 192'(0));
        reset = 1'b0;
        idle(1);
        send_frame(STATUS, 1'b1, 21, pl2, 8'h00, 1);
        idle(1);
        check("t7_fv", 192'(frame_valid), 192'(1));
        check("t7_payload_new", 192'(payload), exp2);
        check("t7_frames_ok_new", 192'(frames_ok), 192'(1));

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
